bcd_history_display: RTL and testbench
======================================

# bcd_history_display

Consumes the 4-bit BCD stream of the up/down counter stage and drives a multiplexed common-anode seven-segment display. The block keeps the last N_DIGITS sampled values, with the newest on digit 0. It tracks the counting direction from successive samples, flags any non-BCD input, and time-multiplexes the stored digits onto one segment bus.

## Interface
Parameters:
- N_DIGITS, default 4: digits of history shown; legal range 2..8.
- REFRESH_DIV, default 50000: clk cycles each digit is lit; minimum 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- sample_en, input, 1: single-cycle strobe; capture bcd_in on this edge.
- bcd_in, input, 4: BCD digit from the counter stage.
- clr_err, input, 1: clears err.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- an, output, N_DIGITS: digit enables, one-hot active-low, registered.
- dir_up, output, 1: 1 = last change was upward, 0 = downward.
- err, output, 1: sticky flag; a non-BCD value (>9) was sampled.

## Operation
- History: N_DIGITS x 4-bit shift register, hist[0] newest.
  - On sample_en: hist[k] <= hist[k-1], and hist[0] <= bcd_in if bcd_in <= 9, else BLANK (4'hF).
  - Without sample_en the history holds.
- Error flag:
  - err sets on sample_en with bcd_in > 9.
  - clr_err clears it.
  - If set and clear happen in the same cycle, set wins.
- Direction, updated only on a sample_en with valid bcd_in and hist[0] != BLANK:
  - bcd_in > hist[0] sets dir_up = 1.
  - bcd_in < hist[0] sets dir_up = 0.
  - Equal values leave dir_up unchanged.
  - At the 9→8 and 0→1 turnarounds, dir_up flips on the sample that carries the new value.
- Scan:
  - refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan_idx advances 0→1→…→N_DIGITS-1→0.
- Decode: seg shows hist[scan_idx] through bcd_to_7seg.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - BLANK and any other code = 7'h7F.
  - an = ~(1 << scan_idx).
- Reset values:
  - hist all BLANK, refresh counter 0, scan_idx 0.
  - seg = 7'h7F, an = ~1 (digit 0 enabled), dir_up = 1, err = 0.

## Timing
- seg and an are registered from scan_idx and hist, giving 1 cycle of latency.
  - A sample captured at edge T appears on seg at edge T+1 if digit 0 is being scanned.
- On the refresh wrap edge, scan_idx changes; an and seg change together one edge later. There are no split-cycle glitches between an and seg.
- Each digit stays enabled for exactly REFRESH_DIV cycles. A full frame is N_DIGITS*REFRESH_DIV cycles.
- sample_en coinciding with a scan wrap: both take effect on that edge. The display then shows the new history on the new digit one cycle later.
- sample_en held high for multiple cycles: one shift per cycle. No edge detection is performed.
- Asserting reset mid-frame immediately forces all reset values. Scanning restarts at digit 0 on the first edge after reset is released.
- dir_up and err are registered and update on the sample edge, with 0 extra latency.

## Structure
- Package bcd_disp_pkg:
  - BLANK code 4'hF.
  - SEG_OFF 7'h7F.
  - Ten digit segment constants.
  - Digit type logic [3:0].
- Sub-module bcd_to_7seg: combinational 4-bit → 7-bit active-low decoder, instantiated once on the scan mux output.
- Top module holds the history shift register, direction/err logic, refresh counter, scan index and output registers.

## Test plan
All scenarios use REFRESH_DIV=4 and N_DIGITS=4.
- Reset then idle 20 cycles:
  - seg=7'h7F throughout.
  - an steps 1110→1101→1011→0111, 4 cycles each.
  - dir_up=1, err=0.
- Sample 3, 4, 5 on consecutive strobes:
  - hist = {BLANK,3,4,5}.
  - While an=1110, seg=7'h12; while an=1101, seg=7'h19; while an=1011, seg=7'h30.
  - dir_up=1.
- Drive the counter sequence 8, 9, 8, 7:
  - dir_up stays 1 through 9, goes 0 on the sample of 8, stays 0 on 7.
  - Repeat across the 1→0→1 turnaround: dir_up returns to 1 on the sample of 1.
- Sample 4'hC:
  - err=1 next cycle; that digit shows 7'h7F; dir_up unchanged.
  - clr_err alone clears err.
  - clr_err together with another 4'hB sample leaves err=1.
- Sample asserted on the refresh wrap edge:
  - The new digit 0 value appears on seg exactly when an next reads 1110, with no intermediate glyph.
- Assert reset in the middle of digit 2 with history loaded:
  - All outputs take reset values during reset.
  - After release, an=1110 and seg=7'h7F.
  - The next sample of 6 displays 7'h02.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD history display.
//   digit_t  : one stored BCD digit (4 bits)
//   BLANK    : code held in history slots that show nothing
//   MAX_BCD  : largest legal BCD value
//   SEG_*    : active-low {g,f,e,d,c,b,a} glyphs for 0..9 and the dark glyph
package bcd_disp_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BLANK   = 4'hF;
  localparam digit_t MAX_BCD = 4'd9;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;

endpackage

// File: rtl/bcd_history_display_if.sv
// Bus between the counter stage and the display block.
//   sample_en : strobe, capture bcd_in this cycle
//   bcd_in    : BCD digit from the counter stage
//   clr_err   : clears the sticky error flag
//   seg       : active-low segments {g,f,e,d,c,b,a}
//   an        : one-hot active-low digit enables
//   dir_up    : 1 = last change was upward
//   err       : sticky non-BCD flag
// master drives the sample side, slave is the display block.
interface bcd_history_display_if #(
  parameter int N_DIGITS = 4
);
  import bcd_disp_pkg::*;

  logic                sample_en;
  digit_t              bcd_in;
  logic                clr_err;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] an;
  logic                dir_up;
  logic                err;

  modport master (
    output sample_en, bcd_in, clr_err,
    input  seg, an, dir_up, err
  );

  modport slave (
    input  sample_en, bcd_in, clr_err,
    output seg, an, dir_up, err
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   digit : 4-bit code; 0..9 decode to glyphs, everything else is dark
//   seg   : {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_history_display.sv
// Keeps the last N_DIGITS sampled BCD values (newest on digit 0), tracks the
// counting direction, flags non-BCD samples and time-multiplexes the stored
// digits onto a common-anode seven-segment display.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of bcd_history_display_if (sample inputs, display
//           and status outputs)
// Parameters: N_DIGITS (2..8) digits shown, REFRESH_DIV (>=2) cycles per digit.
module bcd_history_display
  import bcd_disp_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_history_display_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0]       CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]       IDX_LAST = SW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

  digit_t        hist [N_DIGITS];
  logic [CW-1:0] refresh_cnt;
  logic [SW-1:0] scan_idx;
  logic          wrap;
  logic          bcd_valid;
  digit_t        scan_digit;
  logic [6:0]    seg_next;

  assign bcd_valid = (bus.bcd_in <= MAX_BCD);
  assign wrap      = (refresh_cnt == CNT_LAST);

  // Loop-based mux keeps the index safe when N_DIGITS is not a power of two.
  always_comb begin
    scan_digit = BLANK;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_idx == SW'(i)) scan_digit = hist[i];
    end
  end

  bcd_to_7seg u_dec (
    .digit (scan_digit),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIGITS; i++) hist[i] <= BLANK;
    end else if (bus.sample_en) begin
      for (int i = N_DIGITS - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= bcd_valid ? bus.bcd_in : BLANK;
    end
  end

  // Direction only compares two real digits; a blank newest slot gives no
  // reference. Error set has priority over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dir_up <= 1'b1;
      bus.err    <= 1'b0;
    end else begin
      if (bus.sample_en && bcd_valid && (hist[0] != BLANK)) begin
        if (bus.bcd_in > hist[0])      bus.dir_up <= 1'b1;
        else if (bus.bcd_in < hist[0]) bus.dir_up <= 1'b0;
      end
      if (bus.sample_en && !bcd_valid) bus.err <= 1'b1;
      else if (bus.clr_err)            bus.err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (wrap) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_LAST) ? '0 : scan_idx + SW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // seg and an come from the same scan_idx so they always switch together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.seg <= SEG_OFF;
      bus.an  <= ~AN_ONE;
    end else begin
      bus.seg <= seg_next;
      bus.an  <= ~(AN_ONE << scan_idx);
    end
  end

endmodule

// File: tb/tb_bcd_history_display.sv
// Self-checking bench for bcd_history_display with N_DIGITS=4, REFRESH_DIV=4.
module tb_bcd_history_display;
  import bcd_disp_pkg::*;

  localparam int N = 4;
  localparam int R = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  bcd_history_display_if #(.N_DIGITS(N)) bus ();

  bcd_history_display #(.N_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_hist [N];
  int           m_k;
  bit           m_dir;
  bit           m_err;
  logic [6:0]   exp_seg;
  logic [N-1:0] exp_an;
  bit           cmp_on = 1'b0;

  logic [N-1:0] lit_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) m_hist[i] = 15;
    m_k     = 0;
    m_dir   = 1'b1;
    m_err   = 1'b0;
    exp_seg = 7'h7F;
    exp_an  = 4'b1110;
  endtask

  // Model: digit lit after k edges is (k / R) mod N; outputs lag state by one edge.
  always @(posedge clk or negedge reset) begin
    int sc;
    if (!reset) begin
      modelReset();
    end else begin
      sc      = (m_k / R) % N;
      exp_seg = glyph(m_hist[sc]);
      exp_an  = ~(4'b0001 << sc);
      if (bus.sample_en) begin
        if (bus.bcd_in <= 9 && m_hist[0] != 15) begin
          if (int'(bus.bcd_in) > m_hist[0])      m_dir = 1'b1;
          else if (int'(bus.bcd_in) < m_hist[0]) m_dir = 1'b0;
        end
        for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = (bus.bcd_in <= 9) ? int'(bus.bcd_in) : 15;
      end
      if (bus.sample_en && bus.bcd_in > 9) m_err = 1'b1;
      else if (bus.clr_err)                m_err = 1'b0;
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("seg", bus.seg, exp_seg);
      checkOutput("an", bus.an, exp_an);
      checkOutput("dir_up", bus.dir_up, m_dir);
      checkOutput("err", bus.err, m_err);
    end
  end

  task automatic applyStimulus(bit se, int d, bit ce);
    @(negedge clk);
    bus.sample_en = se;
    bus.bcd_in    = 4'(d);
    bus.clr_err   = ce;
  endtask

  task automatic sampleAndCheck(int d, bit exp_dir, bit exp_err, string name);
    applyStimulus(1'b1, d, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput({name, "_dir"}, bus.dir_up, exp_dir);
    checkOutput({name, "_err"}, bus.err, exp_err);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int d;
    bus.sample_en = 1'b0;
    bus.bcd_in    = 4'd0;
    bus.clr_err   = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);

    checkOutput("rst_seg", bus.seg, 7'h7F);
    checkOutput("rst_an", bus.an, 4'b1110);
    checkOutput("rst_dir", bus.dir_up, 1);
    checkOutput("rst_err", bus.err, 0);

    reset  = 1'b1;
    cmp_on = 1'b1;

    // Idle scan: four cycles per digit, all dark
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("idle_an", bus.an, lit_an[i/4]);
      checkOutput("idle_seg", bus.seg, 7'h7F);
    end
    repeat (4) @(negedge clk);
    checkOutput("idle_dir", bus.dir_up, 1);
    checkOutput("idle_err", bus.err, 0);

    // History 3,4,5
    sampleAndCheck(3, 1'b1, 1'b0, "s3");
    sampleAndCheck(4, 1'b1, 1'b0, "s4");
    sampleAndCheck(5, 1'b1, 1'b0, "s5");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: checkOutput("frame_d0", bus.seg, 7'h12);
        4'b1101: checkOutput("frame_d1", bus.seg, 7'h19);
        4'b1011: checkOutput("frame_d2", bus.seg, 7'h30);
        4'b0111: checkOutput("frame_d3", bus.seg, 7'h7F);
        default: checkOutput("frame_an_onehot", bus.an, 4'b1110);
      endcase
    end

    // Turnarounds 9->8 and 0->1
    sampleAndCheck(8, 1'b1, 1'b0, "s8");
    sampleAndCheck(9, 1'b1, 1'b0, "s9");
    sampleAndCheck(8, 1'b0, 1'b0, "s8b");
    sampleAndCheck(7, 1'b0, 1'b0, "s7");
    sampleAndCheck(1, 1'b0, 1'b0, "s1");
    sampleAndCheck(0, 1'b0, 1'b0, "s0");
    sampleAndCheck(1, 1'b1, 1'b0, "s1b");

    // Non-BCD sample
    sampleAndCheck(12, 1'b1, 1'b1, "sC");
    @(negedge clk);
    w = 0;
    while (bus.an != 4'b1110 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) timeoutFail("wait_digit0_blank");
    else checkOutput("blank_glyph", bus.seg, 7'h7F);

    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("clr_err", bus.err, 0);
    applyStimulus(1'b1, 11, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("set_wins", bus.err, 1);

    // Sample on the wrap edge from digit 3 to digit 0
    w = 0;
    while (((m_k + 1) % 16) != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) timeoutFail("wait_wrap");
    bus.sample_en = 1'b1;
    bus.bcd_in    = 4'd7;
    @(negedge clk);
    bus.sample_en = 1'b0;
    checkOutput("wrap_an_old", bus.an, 4'b0111);
    @(negedge clk);
    checkOutput("wrap_an_new", bus.an, 4'b1110);
    checkOutput("wrap_seg_new", bus.seg, 7'h78);

    // Reset in the middle of digit 2
    w = 0;
    while (exp_an != 4'b1011 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) timeoutFail("wait_digit2");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_seg", bus.seg, 7'h7F);
    checkOutput("mid_rst_an", bus.an, 4'b1110);
    checkOutput("mid_rst_dir", bus.dir_up, 1);
    checkOutput("mid_rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_an", bus.an, 4'b1110);
    checkOutput("post_rst_seg", bus.seg, 7'h7F);
    bus.sample_en = 1'b1;
    bus.bcd_in    = 4'd6;
    @(negedge clk);
    bus.sample_en = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_six", bus.seg, 7'h02);
    checkOutput("post_rst_six_an", bus.an, 4'b1110);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) d = int'($urandom_range(0, 9));
      else                          d = int'($urandom_range(10, 15));
      applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end
    applyStimulus(1'b0, 0, 1'b0);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
